// File: rtl/int_conditioner.sv
// rtl/int_conditioner.sv - synchronise, debounce, edge-detect and pulse-stretch external active-low interrupt pins
module int_conditioner #(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250,
    parameter int PULSE_CYCLES    = 4
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic [CHANNELS-1:0] nint_raw,
    input  logic [CHANNELS-1:0] enable,
    input  logic [CHANNELS-1:0] clr_overrun,
    output logic [CHANNELS-1:0] int_out,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] overrun
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PCNT_INIT = PW'(PULSE_CYCLES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        PULSE = 1'b1
    } state_t;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q, sync_d;
        logic                   stable_q, stable_d;
        logic                   stable_prev_q, stable_prev_d;
        logic [CW-1:0]          cnt_q, cnt_d;
        state_t                 state_q, state_d;
        logic [PW-1:0]          pcnt_q, pcnt_d;
        logic                   int_q, int_d;
        logic                   ovr_q, ovr_d;
        logic                   sync_out;
        logic                   event_w;
        logic                   ovr_set;

        assign sync_out = sync_q[SYNC_STAGES-1];
        // Assertion event: the debounced level fell on the previous edge.
        assign event_w  = stable_prev_q & ~stable_q;

        // Synchroniser shift and debounce: a new level must hold for DEBOUNCE_CYCLES edges.
        always_comb begin
            sync_d        = {sync_q[SYNC_STAGES-2:0], nint_raw[ch]};
            stable_d      = stable_q;
            stable_prev_d = stable_q;
            cnt_d         = '0;
            if (sync_out != stable_q) begin
                if (cnt_q == CNT_MAX) begin
                    stable_d = sync_out;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        // Pulse FSM next state; an event while busy is lost and flagged as overrun.
        always_comb begin
            state_d = state_q;
            pcnt_d  = pcnt_q;
            int_d   = int_q;
            ovr_set = 1'b0;
            case (state_q)
                IDLE: begin
                    if (event_w && enable[ch]) begin
                        state_d = PULSE;
                        pcnt_d  = PCNT_INIT;
                        int_d   = 1'b1;
                    end
                end
                PULSE: begin
                    ovr_set = event_w;
                    if (pcnt_q == '0) begin
                        state_d = IDLE;
                        int_d   = 1'b0;
                    end else begin
                        pcnt_d = pcnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    int_d   = 1'b0;
                end
            endcase
            // Setting wins over a simultaneous clear so no lost event goes unreported.
            if (ovr_set) begin
                ovr_d = 1'b1;
            end else if (clr_overrun[ch]) begin
                ovr_d = 1'b0;
            end else begin
                ovr_d = ovr_q;
            end
        end

        // State registers; reset restores the idle (high) pin level so release creates no event.
        always_ff @(posedge clk or negedge nreset) begin
            if (!nreset) begin
                sync_q        <= '1;
                stable_q      <= 1'b1;
                stable_prev_q <= 1'b1;
                cnt_q         <= '0;
                state_q       <= IDLE;
                pcnt_q        <= '0;
                int_q         <= 1'b0;
                ovr_q         <= 1'b0;
            end else begin
                sync_q        <= sync_d;
                stable_q      <= stable_d;
                stable_prev_q <= stable_prev_d;
                cnt_q         <= cnt_d;
                state_q       <= state_d;
                pcnt_q        <= pcnt_d;
                int_q         <= int_d;
                ovr_q         <= ovr_d;
            end
        end

        assign int_out[ch] = int_q;
        assign level[ch]   = ~stable_q;
        assign overrun[ch] = ovr_q;
    end

endmodule
